// File: rtl/var_delay_line_if.sv
// Sample/handshake bundle for var_delay_line: producer-side strobe, data and delay
// control in one direction, delayed samples and priming status in the other.
interface var_delay_line_if #(
  parameter int MAX_DELAY = 8,
  parameter int WIDTH     = 8,
  parameter int CHANNELS  = 2
);
  localparam int DW = $clog2(MAX_DELAY + 1);

  logic                      in_valid;
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [DW-1:0]             delay_sel;
  logic                      flush;
  logic                      out_valid;
  logic [CHANNELS*WIDTH-1:0] out_data;
  logic                      primed;

  modport master (
    output in_valid, in_data, delay_sel, flush,
    input  out_valid, out_data, primed
  );

  modport slave (
    input  in_valid, in_data, delay_sel, flush,
    output out_valid, out_data, primed
  );
endinterface

// File: rtl/var_delay_line.sv
// Multi-lane circular-buffer delay line, delay counted in accepted samples and retunable at run time.
// Output registered one cycle after the accept; no backpressure, flush/delay change drops history.
module var_delay_line #(
  parameter int MAX_DELAY = 8,
  parameter int WIDTH     = 8,
  parameter int CHANNELS  = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  var_delay_line_if.slave bus
);
  localparam int DW = $clog2(MAX_DELAY + 1);
  localparam int AW = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;
  localparam int BW = CHANNELS * WIDTH;
  localparam logic [DW-1:0] MAX_D    = DW'(MAX_DELAY);
  localparam logic [DW-1:0] ONE_D    = DW'(1);
  localparam logic [AW-1:0] LAST_PTR = AW'(MAX_DELAY - 1);
  localparam logic [DW:0]   MAX_W    = (DW+1)'(MAX_DELAY);

  typedef enum logic {PRIME, RUN} state_t;

  state_t         state, state_nxt;
  logic [DW-1:0]  d_act, d_new, fill, fill_inc;
  logic [AW-1:0]  wptr, rd_ptr;
  logic [DW:0]    rd_sum;
  logic [BW-1:0]  mem [MAX_DELAY];
  logic           restart, accept;
  logic           out_valid_q;
  logic [BW-1:0]  out_data_q;

  always_comb begin
    d_new = bus.delay_sel;
    if (bus.delay_sel == '0) begin
      d_new = ONE_D;
    end else if (bus.delay_sel > MAX_D) begin
      d_new = MAX_D;
    end
  end

  assign restart  = bus.flush || (d_new != d_act);
  assign accept   = bus.in_valid && !restart;
  assign fill_inc = (fill == MAX_D) ? fill : fill + ONE_D;

  // Oldest wanted sample sits D_act-1 slots behind the write pointer, modulo buffer depth.
  assign rd_sum = (DW+1)'(wptr) + MAX_W - {1'b0, d_act - ONE_D};
  assign rd_ptr = AW'((rd_sum >= MAX_W) ? rd_sum - MAX_W : rd_sum);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (restart) begin
      state_nxt = (d_new == ONE_D) ? RUN : PRIME;
    end else if (accept && (fill_inc >= d_act - ONE_D)) begin
      state_nxt = RUN;
    end
  end

  always_comb begin
    bus.primed = (state == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_act       <= ONE_D;
      fill        <= '0;
      wptr        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      d_act <= d_new;
      if (restart) begin
        fill        <= '0;
        out_valid_q <= 1'b0;
      end else if (bus.in_valid) begin
        wptr        <= (wptr == LAST_PTR) ? '0 : wptr + 1'b1;
        fill        <= fill_inc;
        out_valid_q <= (state == RUN);
        // Only refresh data when a real delayed sample exists, so stale slots never leak out.
        if (state == RUN) begin
          out_data_q <= (d_act == ONE_D) ? bus.in_data : mem[rd_ptr];
        end
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wptr] <= bus.in_data;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
endmodule
